commit_trace_unit: RTL and testbench
====================================

COMMIT_TRACE_UNIT -- requirements
Module: commit_trace_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 16, register/memory data width.
- ADDR_W, 16, PC and memory address width.
- REG_W, 4, register index width.
- DEPTH, 16, record FIFO entries; power of two, at least 2.
- CNT_W, 32, cycle/instruction counter width.
- CYCLE_LIMIT, 100000, watchdog cycle limit.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1 clock.
- rst_n in 1 reset, synchronous, active-low.
- commit_valid in 1 an instruction retires this cycle.
- c_pc in ADDR_W PC of the retiring instruction.
- c_reg_wr in 1 register write.
- c_wr_reg in REG_W destination register.
- c_wr_data in DATA_W register write data.
- c_mem_rd in 1 memory read.
- c_mem_wr in 1 memory write.
- c_mem_addr in ADDR_W memory address.
- c_mem_data in DATA_W store data.
- c_halt in 1 halt retires.
- rec_valid out 1 FIFO head valid.
- rec_ready in 1 consumer accepts the head.
- rec_kind out 3 record kind: 0 NOP, 1 REG, 2 LOAD, 3 STORE, 4 HALT.
- rec_inum out CNT_W instruction number.
- rec_pc out ADDR_W PC.
- rec_reg out REG_W register index.
- rec_value out DATA_W value.
- rec_addr out ADDR_W address.
- cycle_count out CNT_W cycle counter.
- inst_count out CNT_W instruction counter.
- drop_count out CNT_W dropped records.
- overflow out 1 sticky: a record was dropped.
- done out 1 halt seen and FIFO drained.
- timeout out 1 watchdog fired.

Function
REQ-003 States: RUN, DRAIN, DONE, TIMEOUT; the state is RUN after reset.
REQ-004 A commit is accepted only when commit_valid=1 on a clk rising edge in RUN; in every other state commit_valid is ignored.
REQ-005 Classification priority, first match wins:
- c_reg_wr and c_mem_rd: LOAD (reg, value=c_wr_data, addr).
- c_reg_wr: REG.
- c_halt: HALT.
- c_mem_wr: STORE (addr, value=c_mem_data).
- otherwise: NOP.
REQ-006 Fields not used by a record kind are zero.
REQ-007 Each accepted commit is stamped rec_inum = inst_count before increment; inst_count then increments by 1.
REQ-008 Enqueue latency: a record accepted at edge N appears at the FIFO head, with rec_valid=1, after edge N when the FIFO was empty; otherwise it is ordered FIFO.
REQ-009 Pop occurs on an edge where rec_valid and rec_ready are both 1; record fields are stable while rec_valid=1 and rec_ready=0.
REQ-010 Full FIFO, accepted commit, no pop on the same edge: the record is dropped, drop_count increments, overflow is set to 1 (sticky), and inst_count still increments.
REQ-011 Full FIFO with a simultaneous pop and push: both occur and nothing is dropped.
REQ-012 Empty FIFO: rec_valid=0 and no pop occurs.
REQ-013 FIFO pointers wrap modulo DEPTH.
REQ-014 An accepted HALT, including a dropped one, moves RUN to DRAIN.
REQ-015 DRAIN moves to DONE on the first edge on which the FIFO is empty after that edge; done=1 in DONE.
REQ-016 DONE is terminal until reset.
REQ-017 cycle_count increments on every edge after reset release and saturates at all-ones; inst_count and drop_count also saturate.

Reset
REQ-018 When rst_n=0 at a rising edge, the block enters RUN, FIFO empty, all counters 0, and overflow, done, timeout, rec_valid all 0.
REQ-019 Reset mid-operation discards all queued records, including undrained records.
REQ-020 rec_* fields are 0 while rec_valid=0 after reset.

Configuration
REQ-021 With macro TRACE_TIMEOUT_EN defined, RUN moves to TIMEOUT on the edge on which cycle_count reaches CYCLE_LIMIT. In TIMEOUT:
- timeout=1;
- commits are ignored;
- the FIFO still drains;
- the state is terminal until reset.
REQ-022 With TRACE_TIMEOUT_EN undefined, no watchdog logic exists, timeout is tied to 0, and CYCLE_LIMIT is unused.
REQ-023 A HALT and the limit on the same edge: the HALT wins and the state moves to DRAIN.

Verification
REQ-024 The bench shall cover these directed scenarios:
- REG commit: pc=0x0002, reg 3, data 0x00A5, rec_ready=1 -> record kind 1, inum 0, reg 3, value 0x00A5 at the head one cycle later; inst_count=1.
- LOAD then STORE: load reg 1 = 0x1234 from 0x0040, then store 0x5555 to 0x0042 -> kinds 2 then 3 with addr/value as given, inum 0 then 1.
- Overflow: DEPTH=4, rec_ready=0, 6 commits -> 4 records held, drop_count=2, overflow=1, inst_count=6; then drain -> inums 0..3 in order.
- Halt: 2 commits then halt, rec_ready=0 for 5 cycles then 1 -> state DRAIN, HALT inum 2, done=1 the cycle after the last pop, later commits ignored.
- Watchdog (TRACE_TIMEOUT_EN, CYCLE_LIMIT=50): no halt -> timeout=1 when cycle_count=50, and subsequent commits do not change inst_count.
- Reset mid-DRAIN: rst_n=0 for one edge -> rec_valid=0, all counters 0, state RUN.

Source files
------------

// File: rtl/commit_trace_unit.sv
// Commit trace unit: classifies retiring instructions into trace records and queues them in a FIFO.
// The optional cycle watchdog is built only when TRACE_TIMEOUT_EN is defined.
module commit_trace_unit #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned CYCLE_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] c_pc,
    input  logic              c_reg_wr,
    input  logic [REG_W-1:0]  c_wr_reg,
    input  logic [DATA_W-1:0] c_wr_data,
    input  logic              c_mem_rd,
    input  logic              c_mem_wr,
    input  logic [ADDR_W-1:0] c_mem_addr,
    input  logic [DATA_W-1:0] c_mem_data,
    input  logic              c_halt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_kind,
    output logic [CNT_W-1:0]  rec_inum,
    output logic [ADDR_W-1:0] rec_pc,
    output logic [REG_W-1:0]  rec_reg,
    output logic [DATA_W-1:0] rec_value,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              done,
    output logic              timeout
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] KIND_NOP   = 3'd0;
    localparam logic [2:0] KIND_REG   = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_STORE = 3'd3;
    localparam logic [2:0] KIND_HALT  = 3'd4;

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [ADDR_W-1:0] pc;
        logic [REG_W-1:0]  regIdx;
        logic [DATA_W-1:0] value;
        logic [ADDR_W-1:0] addr;
    } rec_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic              acceptC;
    logic              doneNext;

    rec_t              mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  rdPtrNext;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fillNext;
    logic              popC;
    logic              pushC;
    logic              dropC;
    logic              fullC;
    rec_t              newRec;
    rec_t              headNext;

    // Record classification; the first matching rule wins and unused fields stay zero.
    always_comb begin
        newRec      = '0;
        newRec.inum = inst_count;
        newRec.pc   = c_pc;
        if (c_reg_wr && c_mem_rd) begin
            newRec.kind   = KIND_LOAD;
            newRec.regIdx = c_wr_reg;
            newRec.value  = c_wr_data;
            newRec.addr   = c_mem_addr;
        end else if (c_reg_wr) begin
            newRec.kind   = KIND_REG;
            newRec.regIdx = c_wr_reg;
            newRec.value  = c_wr_data;
        end else if (c_halt) begin
            newRec.kind   = KIND_HALT;
        end else if (c_mem_wr) begin
            newRec.kind   = KIND_STORE;
            newRec.value  = c_mem_data;
            newRec.addr   = c_mem_addr;
        end else begin
            newRec.kind   = KIND_NOP;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; a HALT takes priority over the watchdog limit.
    always_comb begin
        stateNext = state;
        case (state)
            RUN: begin
                if (acceptC && (newRec.kind == KIND_HALT)) begin
                    stateNext = DRAIN;
                end
`ifdef TRACE_TIMEOUT_EN
                else if (cycle_count == CNT_W'(CYCLE_LIMIT - 1)) begin
                    stateNext = TIMEOUT;
                end
`endif
            end
            DRAIN: begin
                if (fillNext == '0) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = DONE;
            TIMEOUT: stateNext = TIMEOUT;
            default: stateNext = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        acceptC  = 1'b0;
        doneNext = 1'b0;
        if (state == RUN) begin
            acceptC = commit_valid;
        end
        if (stateNext == DONE) begin
            doneNext = 1'b1;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head pops on the same edge.
    always_comb begin
        popC      = rec_valid && rec_ready;
        fullC     = (fill == FILL_W'(DEPTH));
        pushC     = acceptC && (!fullC || popC);
        dropC     = acceptC && fullC && !popC;
        rdPtrNext = popC ? rdPtr + PTR_W'(1) : rdPtr;
        fillNext  = fill;
        if (pushC && !popC) begin
            fillNext = fill + FILL_W'(1);
        end else if (!pushC && popC) begin
            fillNext = fill - FILL_W'(1);
        end
    end

    // Head for the next cycle: the incoming record bypasses storage when it becomes the only entry.
    always_comb begin
        headNext = mem[rdPtrNext];
        if (pushC && (fillNext == FILL_W'(1))) begin
            headNext = newRec;
        end
    end

    always_ff @(posedge clk) begin
        if (pushC) begin
            mem[wrPtr] <= newRec;
        end
    end

    // Pointers, registered head outputs and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            fill        <= '0;
            rec_valid   <= 1'b0;
            rec_kind    <= '0;
            rec_inum    <= '0;
            rec_pc      <= '0;
            rec_reg     <= '0;
            rec_value   <= '0;
            rec_addr    <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (pushC) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdPtrNext;
            fill  <= fillNext;
            if (fillNext != '0) begin
                rec_valid <= 1'b1;
                rec_kind  <= headNext.kind;
                rec_inum  <= headNext.inum;
                rec_pc    <= headNext.pc;
                rec_reg   <= headNext.regIdx;
                rec_value <= headNext.value;
                rec_addr  <= headNext.addr;
            end else begin
                rec_valid <= 1'b0;
                rec_kind  <= '0;
                rec_inum  <= '0;
                rec_pc    <= '0;
                rec_reg   <= '0;
                rec_value <= '0;
                rec_addr  <= '0;
            end
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (acceptC && (inst_count != '1)) begin
                inst_count <= inst_count + CNT_W'(1);
            end
            if (dropC) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end
            done <= doneNext;
        end
    end

`ifdef TRACE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= (stateNext == TIMEOUT);
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed self-checking bench for commit_trace_unit (DEPTH=4, CYCLE_LIMIT=50).
`timescale 1ns/1ps
module tb_commit_trace_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid;
    logic [15:0] c_pc;
    logic        c_reg_wr;
    logic [3:0]  c_wr_reg;
    logic [15:0] c_wr_data;
    logic        c_mem_rd;
    logic        c_mem_wr;
    logic [15:0] c_mem_addr;
    logic [15:0] c_mem_data;
    logic        c_halt;
    logic        rec_valid;
    logic        rec_ready;
    logic [2:0]  rec_kind;
    logic [31:0] rec_inum;
    logic [15:0] rec_pc;
    logic [3:0]  rec_reg;
    logic [15:0] rec_value;
    logic [15:0] rec_addr;
    logic [31:0] cycle_count;
    logic [31:0] inst_count;
    logic [31:0] drop_count;
    logic        overflow;
    logic        done;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    commit_trace_unit #(
        .DATA_W(16), .ADDR_W(16), .REG_W(4), .DEPTH(4), .CNT_W(32), .CYCLE_LIMIT(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .c_pc(c_pc),
        .c_reg_wr(c_reg_wr), .c_wr_reg(c_wr_reg), .c_wr_data(c_wr_data),
        .c_mem_rd(c_mem_rd), .c_mem_wr(c_mem_wr), .c_mem_addr(c_mem_addr),
        .c_mem_data(c_mem_data), .c_halt(c_halt), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
        .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value),
        .rec_addr(rec_addr), .cycle_count(cycle_count), .inst_count(inst_count),
        .drop_count(drop_count), .overflow(overflow), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after the edge and inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic regWr,
                         input logic [3:0] wr, input logic [15:0] wd, input logic mr,
                         input logic mw, input logic [15:0] ma, input logic [15:0] md,
                         input logic h);
        commit_valid = v;  c_pc = pc;       c_reg_wr = regWr; c_wr_reg = wr;
        c_wr_data = wd;    c_mem_rd = mr;   c_mem_wr = mw;    c_mem_addr = ma;
        c_mem_data = md;   c_halt = h;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        rec_ready = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rec_ready = 1'b0;
        idle();
        step();

        // Reset state and a single REG commit.
        doReset();
        checkEq("rst_valid", 64'(rec_valid), 64'd0);
        checkEq("rst_cycle", 64'(cycle_count), 64'd0);
        checkEq("rst_inst", 64'(inst_count), 64'd0);
        checkEq("rst_flags", {61'd0, overflow, done, timeout}, 64'd0);
        checkEq("rst_fields", {rec_kind, rec_inum, rec_pc, rec_reg, rec_value}, 64'd0);
        rec_ready = 1'b1;
        drive(1'b1, 16'h0002, 1'b1, 4'd3, 16'h00A5, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        idle();
        checkEq("reg_valid", 64'(rec_valid), 64'd1);
        checkEq("reg_rec", {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr},
                {3'd1, 32'd0, 16'h0002, 4'd3, 16'h00A5, 16'h0000});
        checkEq("reg_inst", 64'(inst_count), 64'd1);
        step();
        checkEq("reg_popped", 64'(rec_valid), 64'd0);
        checkEq("reg_cycle", 64'(cycle_count), 64'd2);

        // LOAD then STORE, head held while the consumer stalls.
        doReset();
        drive(1'b1, 16'h0010, 1'b1, 4'd1, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'hFFFF, 1'b0);
        step();
        drive(1'b1, 16'h0012, 1'b0, 4'd7, 16'hEEEE, 1'b0, 1'b1, 16'h0042, 16'h5555, 1'b0);
        step();
        idle();
        checkEq("load_rec", {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr},
                {3'd2, 32'd0, 16'h0010, 4'd1, 16'h1234, 16'h0040});
        rec_ready = 1'b1;
        step();
        checkEq("store_rec", {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr},
                {3'd3, 32'd1, 16'h0012, 4'd0, 16'h5555, 16'h0042});
        step();
        checkEq("ls_empty", {61'd0, rec_valid, rec_kind}, 64'd0);

        // Overflow: 6 NOPs into 4 entries, then a push and pop together on a full FIFO.
        doReset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(i), 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            step();
        end
        idle();
        checkEq("ovf_drop", 64'(drop_count), 64'd2);
        checkEq("ovf_flag", 64'(overflow), 64'd1);
        checkEq("ovf_inst", 64'(inst_count), 64'd6);
        checkEq("ovf_head", {rec_valid, rec_kind, rec_inum, rec_pc}, {1'b1, 3'd0, 32'd0, 16'd0});
        rec_ready = 1'b1;
        drive(1'b1, 16'h0006, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        idle();
        checkEq("full_pushpop_drop", 64'(drop_count), 64'd2);
        checkEq("full_pushpop_inst", 64'(inst_count), 64'd7);
        for (int i = 1; i < 4; i++) begin
            checkEq($sformatf("drain_inum%0d", i), {rec_valid, rec_inum, rec_pc},
                    {1'b1, 32'(i), 16'(i)});
            step();
        end
        checkEq("drain_inum6", {rec_valid, rec_inum, rec_pc}, {1'b1, 32'd6, 16'd6});
        step();
        checkEq("drain_empty", 64'(rec_valid), 64'd0);
        checkEq("ovf_sticky", 64'(overflow), 64'd1);

        // Halt: two commits then HALT, commits ignored in DRAIN, done after last pop.
        doReset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'(16 + i), 1'b1, 4'(i + 2), 16'(16'h100 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            step();
        end
        drive(1'b1, 16'h0020, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();
        drive(1'b1, 16'h0030, 1'b1, 4'd9, 16'h9999, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        checkEq("halt_ignored", 64'(inst_count), 64'd3);
        checkEq("halt_not_done", 64'(done), 64'd0);
        idle();
        rec_ready = 1'b1;
        checkEq("halt_head0", {rec_kind, rec_inum, rec_pc}, {3'd1, 32'd0, 16'h0010});
        step();
        checkEq("halt_head1", {rec_kind, rec_inum, rec_reg, rec_value}, {3'd1, 32'd1, 4'd3, 16'h0101});
        step();
        checkEq("halt_rec", {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr},
                {3'd4, 32'd2, 16'h0020, 4'd0, 16'h0, 16'h0});
        checkEq("halt_done_pending", 64'(done), 64'd0);
        step();
        checkEq("halt_done", {rec_valid, done}, 64'b01);
        drive(1'b1, 16'h0040, 1'b1, 4'd1, 16'h1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        idle();
        checkEq("done_ignored", {inst_count, 31'd0, done}, {32'd3, 32'd1});

        // Watchdog: limit reached at cycle_count=50 only when the feature is built.
        doReset();
        rec_ready = 1'b1;
        drive(1'b1, 16'h0050, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        idle();
        for (int n = 0; n < 100 && cycle_count < 32'd49; n++) begin
            step();
        end
        checkEq("wd_cycle49", 64'(cycle_count), 64'd49);
        checkEq("wd_before", 64'(timeout), 64'd0);
        step();
        checkEq("wd_cycle50", 64'(cycle_count), 64'd50);
        drive(1'b1, 16'h0052, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        idle();
`ifdef TRACE_TIMEOUT_EN
        checkEq("wd_timeout", 64'(timeout), 64'd1);
        checkEq("wd_inst_frozen", 64'(inst_count), 64'd1);
`else
        checkEq("wd_timeout", 64'(timeout), 64'd0);
        checkEq("wd_inst_counts", 64'(inst_count), 64'd2);
`endif

        // Reset in the middle of DRAIN discards queued records.
        doReset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'(i), 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            step();
        end
        drive(1'b1, 16'h0002, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();
        idle();
        checkEq("rd_pre_valid", {rec_valid, inst_count}, {1'b1, 32'd3});
        doReset();
        checkEq("rd_valid", 64'(rec_valid), 64'd0);
        checkEq("rd_counters", {cycle_count, inst_count}, 64'd0);
        checkEq("rd_drop_flags", {drop_count, 29'd0, overflow, done, timeout}, 64'd0);
        checkEq("rd_fields", {rec_kind, rec_inum, rec_pc, rec_reg}, 64'd0);
        rec_ready = 1'b0;
        drive(1'b1, 16'h0077, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 16'h0080, 16'h00CC, 1'b0);
        step();
        idle();
        checkEq("rd_run_accept", {rec_valid, rec_kind, rec_inum, rec_value, inst_count[11:0]},
                {1'b1, 3'd3, 32'd0, 16'h00CC, 12'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
